axi_wr_burst_sched: RTL and testbench
=====================================

// Module: axi_wr_burst_sched
// PURPOSE
// - Write-side scheduler for the dual-read FIFO's sync read port, in the w_clk domain.
// - Counts words pushed into the FIFO and groups them into INCR bursts.
// - Drives the AXI master write address (AW), data (W) and response (B) channels.
// - Pops the FIFO via en_read_sync on every accepted W beat, so buffered payload reaches memory.
// PARAMETERS
// - DATA_WIDTH  32  FIFO/AXI data width in bits; must be a power of two, at least 8
// - FIFO_DEPTH  8   FIFO entries; sets the maximum level the counter tracks
// - BURST_LEN   4   maximum beats per burst; 1 <= BURST_LEN <= FIFO_DEPTH and BURST_LEN <= 256
// - ADDR_WIDTH  32  AXI byte-address width
// - CNT_WIDTH   16  width of the transfer word count
// PORTS
// - w_clk            in   1           sync clock; same clock as the FIFO write side
// - wrst_n           in   1           asynchronous active-low reset
// - cfg_start        in   1           1-cycle pulse; latches cfg_base_addr and cfg_total_words
// - cfg_base_addr    in   ADDR_WIDTH  start byte address; aligned to BURST_LEN*DATA_WIDTH/8
// - cfg_total_words  in   CNT_WIDTH   words to move; 0 = finish at once
// - wr_push          in   1           FIFO write accepted (en_write & ~fifo_full)
// - fifo_data        in   DATA_WIDTH  FIFO data_out_sync
// - en_read_sync     out  1           FIFO sync pop strobe
// - aw_valid         out  1           AXI AW valid
// - aw_ready         in   1           AXI AW ready
// - aw_addr          out  ADDR_WIDTH  AXI AW byte address
// - aw_len           out  8           AXI AW length (beats-1)
// - w_valid          out  1           AXI W valid
// - w_ready          in   1           AXI W ready
// - w_data           out  DATA_WIDTH  AXI W data
// - w_last           out  1           AXI W last beat
// - b_valid          in   1           AXI B valid
// - b_ready          out  1           AXI B ready
// - b_resp           in   2           AXI B response
// - busy             out  1           a transfer is in progress
// - done             out  1           1-cycle pulse when the transfer completes
// - err              out  1           sticky slave-error flag
// BEHAVIOUR
// - Clock/reset: one clock (w_clk); reset wrst_n is asynchronous, active-low.
//   - Reset values: FSM=IDLE, level=0, all outputs 0.
//   - Asserting reset mid-burst abandons the burst; no AXI cleanup is performed.
// - Level counter: level += wr_push, level -= en_read_sync; both in the same cycle leaves it unchanged.
//   - Tracks pushes even in IDLE.
//   - wr_push at level==FIFO_DEPTH is illegal and must be caught by an assertion.
// - Beat count: beats = min(BURST_LEN, remaining); w_data = fifo_data (combinational).
// - Handshake rule: en_read_sync = w_valid & w_ready, so it pops exactly one word per accepted beat.
// - FSM IDLE: on cfg_start, latch addr and remaining.
//   - Go to REQ, or raise done the next cycle if remaining==0.
//   - busy=0 in IDLE; err clears on cfg_start.
//   - cfg_start while busy is ignored.
// - FSM REQ: wait until level >= beats, then assert aw_valid with aw_addr=addr and aw_len=beats-1.
//   - Hold AW stable until aw_ready; then go to DATA.
// - FSM DATA: w_valid is high while the beat counter < beats.
//   - The level is guaranteed by REQ.
//   - w_last is high on beat beats-1; the w_valid&w_ready&w_last handshake moves to RESP.
// - FSM RESP: b_ready=1; on b_valid:
//   - err |= (b_resp!=2'b00);
//   - addr += beats*DATA_WIDTH/8, with ADDR_WIDTH wrap;
//   - remaining -= beats;
//   - go to REQ if remaining!=0, else IDLE with a done pulse.
// - An error response does not abort; the remaining bursts still issue.
// - AW and W are strictly sequential (no W before AW accepted); one outstanding burst at a time.
// STRUCTURE
// - Shared package axi_wr_pkg holds:
//   - FSM state enum {IDLE,REQ,DATA,RESP};
//   - AXI_RESP_OKAY=2'b00;
//   - the localparam BYTES_PER_BEAT.
// - Sub-module fifo_level_cnt: up/down counter, $clog2(FIFO_DEPTH+1) bits, with overflow/underflow assertions.
// - The FSM and address/remaining datapath stay in the top module.
// TESTING
// - Reset: hold wrst_n=0 mid-DATA -> all outputs 0 within the same cycle; FSM=IDLE after release.
// - Single transfer: base=0x1000, total=4, 4 pushes -> one AW with addr=0x1000, len=3.
//   - Then 4 W beats with w_last on the 4th, 4 en_read_sync pulses, one done pulse, level=0.
// - Partial last burst: total=10, BURST_LEN=4 -> AW addrs 0x1000, 0x1010, 0x1020 with len 3, 3, 1.
// - Backpressure and late data: 2 pushes, then stall -> aw_valid stays 0 until level>=4.
//   - Toggling w_ready low holds w_data/w_last stable and produces no pop.
// - Error response: b_resp=2'b10 on burst 1 of 2 -> err=1; burst 2 still issues.
//   - done pulses and err stays 1 until the next cfg_start.
// - Edge cases:
//   - total=0 -> done one cycle after cfg_start, no AXI activity;
//   - cfg_start while busy -> ignored;
//   - simultaneous push and pop -> level unchanged.

Source files
------------

// File: rtl/axi_wr_burst_sched_pkg.sv
// Shared types and constants for the AXI write-burst scheduler.
// State encoding, AXI response codes and beat-size helpers.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam int         DATA_WIDTH_DFLT = 32;
    localparam int         BYTES_PER_BEAT  = DATA_WIDTH_DFLT / 8;

    function automatic int beat_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_wr_burst_sched_if.sv
// AXI write-side channels (AW, W, B) between the scheduler and the memory slave.
// Master drives requests and data; the slave drives readiness and the response.
interface axi_wr_burst_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_last;
    logic                  b_valid;
    logic                  b_ready;
    logic [1:0]            b_resp;

    modport master (
        output aw_valid, aw_addr, aw_len,
        output w_valid, w_data, w_last,
        output b_ready,
        input  aw_ready, w_ready, b_valid, b_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len,
        input  w_valid, w_data, w_last,
        input  b_ready,
        output aw_ready, w_ready, b_valid, b_resp
    );

endinterface

// File: rtl/axi_wr_burst_sched_fifo_level_cnt.sv
// Occupancy tracker for the FIFO: +1 per push, -1 per pop, registered (1-cycle latency).
// No backpressure of its own; a push when full or a pop when empty is flagged by assertion.
module fifo_level_cnt #(
    parameter int FIFO_DEPTH = 8,
    parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [LW-1:0] level_o
);

    logic [LW-1:0] level_q, level_d;

    always_comb begin
        level_d = level_q;
        case ({inc_i, dec_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc_i && (level_q == LW'(FIFO_DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec_i && (level_q == '0)));

endmodule

// File: rtl/axi_wr_burst_sched.sv
// Groups FIFO words into INCR bursts and drives AXI AW/W/B; W data is combinational from the FIFO.
// AW waits for enough buffered words; W stalls on w_ready without popping; one burst outstanding.
module axi_wr_burst_sched
    import axi_wr_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  w_clk,
    input  logic                  wrst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]  cfg_total_words,
    input  logic                  wr_push,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  en_read_sync,
    axi_wr_burst_sched_if.master  axi,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int LW         = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_BYTES = beat_bytes(DATA_WIDTH);
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic [8:0]            beat_q, beat_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [8:0]            beats;
    logic [LW-1:0]         level;
    logic                  level_ok;
    logic [ADDR_WIDTH-1:0] addr_incr;
    logic                  w_vld;
    logic                  w_lst;

    fifo_level_cnt #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LW         (LW)
    ) u_lvl (
        .clk     (w_clk),
        .rst_n   (wrst_n),
        .inc_i   (wr_push),
        .dec_i   (en_read_sync),
        .level_o (level)
    );

    // Burst size is a function of remaining only, so it stays fixed from REQ through RESP.
    always_comb begin
        beats = 9'(BURST_LEN);
        if (rem_q < CNT_WIDTH'(BURST_LEN)) begin
            beats = 9'(rem_q);
        end
    end

    assign level_ok  = 32'(level) >= 32'(beats);
    assign addr_incr = ADDR_WIDTH'(beats) << BEAT_SHIFT;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        beat_d       = beat_q;
        done_d       = 1'b0;
        err_d        = err_q;
        w_vld        = 1'b0;
        w_lst        = 1'b0;
        axi.aw_valid = 1'b0;
        axi.aw_addr  = '0;
        axi.aw_len   = '0;
        axi.w_valid  = 1'b0;
        axi.w_data   = '0;
        axi.w_last   = 1'b0;
        axi.b_ready  = 1'b0;
        en_read_sync = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    addr_d = cfg_base_addr;
                    rem_d  = cfg_total_words;
                    err_d  = 1'b0;
                    if (cfg_total_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end

            REQ: begin
                // Nothing pops in REQ, so once level_ok rises AW stays asserted and stable.
                if (level_ok) begin
                    axi.aw_valid = 1'b1;
                    axi.aw_addr  = addr_q;
                    axi.aw_len   = 8'(beats - 9'd1);
                    if (axi.aw_ready) begin
                        state_d = DATA;
                        beat_d  = '0;
                    end
                end
            end

            DATA: begin
                w_vld        = beat_q < beats;
                w_lst        = beat_q == (beats - 9'd1);
                axi.w_valid  = w_vld;
                axi.w_last   = w_lst;
                axi.w_data   = fifo_data;
                en_read_sync = w_vld & axi.w_ready;
                if (w_vld && axi.w_ready) begin
                    beat_d = beat_q + 9'd1;
                    if (w_lst) begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                axi.b_ready = 1'b1;
                if (axi.b_valid) begin
                    err_d  = err_q | (axi.b_resp != AXI_RESP_OKAY);
                    addr_d = addr_q + addr_incr;
                    rem_d  = rem_q - CNT_WIDTH'(beats);
                    if (rem_q != CNT_WIDTH'(beats)) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Directed bench for axi_wr_burst_sched: FIFO and AXI slave models plus an expected-burst scoreboard.
module tb_axi_wr_burst_sched;
    import axi_wr_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 8;
    localparam int BL    = 4;

    logic          w_clk = 1'b0;
    logic          wrst_n;
    logic          cfg_start;
    logic [AW-1:0] cfg_base_addr;
    logic [CW-1:0] cfg_total_words;
    logic          wr_push;
    logic [DW-1:0] fifo_data;
    logic          en_read_sync;
    logic          busy;
    logic          done;
    logic          err;

    always #5 w_clk = ~w_clk;

    axi_wr_burst_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axi_wr_burst_sched #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .BURST_LEN  (BL),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .w_clk           (w_clk),
        .wrst_n          (wrst_n),
        .cfg_start       (cfg_start),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_total_words (cfg_total_words),
        .wr_push         (wr_push),
        .fifo_data       (fifo_data),
        .en_read_sync    (en_read_sync),
        .axi             (axi),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } aw_exp_t;

    aw_exp_t       exp_aw[$];
    bit            exp_last[$];
    logic [DW-1:0] fifo_q[$];
    logic [1:0]    resp_q[$];

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_aw, n_pop, n_done, n_both, n_stall;
    int push_left = 0;
    int w_mode = 0;
    bit aw_rdy_en = 1'b1;
    bit b_pend = 1'b0, b_taken = 1'b0, stall_prev = 1'b0, both_prev = 1'b0;
    logic [DW-1:0] stall_dat;
    logic          stall_last;
    int            both_lvl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_aw = 0; n_pop = 0; n_done = 0; n_both = 0; n_stall = 0;
    endtask

    // Expected burst split: chunks of BL words, last chunk partial, address advancing by bytes moved.
    task automatic plan(input logic [AW-1:0] base, input int total);
        int            rem;
        int            b;
        logic [AW-1:0] a;
        rem = total;
        a   = base;
        while (rem > 0) begin
            b = (rem < BL) ? rem : BL;
            exp_aw.push_back(aw_exp_t'{addr: a, len: 8'(b - 1)});
            for (int i = 0; i < b; i++) exp_last.push_back(i == b - 1);
            a   = a + AW'(b * (DW / 8));
            rem = rem - b;
        end
    endtask

    // One clock: observe at the falling edge, then drive slave/FIFO inputs just after the rising edge.
    task automatic cyc();
        aw_exp_t e;
        bit      lst;
        @(negedge w_clk);
        chk("level_model", 64'(dut.level), 64'(fifo_q.size()));
        if (both_prev) chk("pushpop_level", 64'(dut.level), 64'(both_lvl));
        if (axi.aw_valid) begin
            chk("aw_level_ok", 64'(int'(dut.level) >= int'(axi.aw_len) + 1), 64'(1));
            if (axi.aw_ready) begin
                n_aw++;
                chk("aw_expected", 64'(exp_aw.size() > 0), 64'(1));
                if (exp_aw.size() > 0) begin
                    e = exp_aw.pop_front();
                    chk("aw_addr", 64'(axi.aw_addr), 64'(e.addr));
                    chk("aw_len", 64'(axi.aw_len), 64'(e.len));
                end
            end
        end
        if (stall_prev && axi.w_valid) begin
            chk("stall_w_data", 64'(axi.w_data), 64'(stall_dat));
            chk("stall_w_last", 64'(axi.w_last), 64'(stall_last));
        end
        if (axi.w_valid && axi.w_ready) begin
            n_pop++;
            chk("w_pop", 64'(en_read_sync), 64'(1));
            chk("w_have_data", 64'(fifo_q.size() > 0), 64'(1));
            if (fifo_q.size() > 0) chk("w_data", 64'(axi.w_data), 64'(fifo_q[0]));
            lst = (exp_last.size() > 0) ? exp_last.pop_front() : 1'b0;
            chk("w_last", 64'(axi.w_last), 64'(lst));
            if (axi.w_last) b_pend = 1'b1;
        end else begin
            chk("no_pop", 64'(en_read_sync), 64'(0));
        end
        stall_prev = axi.w_valid && !axi.w_ready;
        if (stall_prev) begin
            n_stall++;
            stall_dat  = axi.w_data;
            stall_last = axi.w_last;
        end
        if (axi.b_valid) chk("b_ready", 64'(axi.b_ready), 64'(1));
        b_taken   = axi.b_valid && axi.b_ready;
        both_prev = en_read_sync && wr_push;
        both_lvl  = int'(dut.level);
        if (both_prev) n_both++;
        if (done) n_done++;
        if (en_read_sync && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (wr_push) fifo_q.push_back($urandom);
        fifo_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;

        @(posedge w_clk);
        #1;
        if (b_taken) begin
            axi.b_valid = 1'b0;
            b_taken     = 1'b0;
        end else if (b_pend && !axi.b_valid) begin
            axi.b_valid = 1'b1;
            axi.b_resp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
            b_pend      = 1'b0;
        end
        case (w_mode)
            1:       axi.w_ready = ~axi.w_ready;
            2:       axi.w_ready = 1'b0;
            default: axi.w_ready = 1'b1;
        endcase
        axi.aw_ready = aw_rdy_en;
        wr_push = (push_left > 0) && (fifo_q.size() < DEPTH);
        if (wr_push) push_left--;
    endtask

    task automatic start(input logic [AW-1:0] base, input int total);
        cfg_base_addr   = base;
        cfg_total_words = CW'(total);
        cfg_start       = 1'b1;
        cyc();
        cfg_start       = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start_n;
        int k;
        start_n = n_done;
        k       = 0;
        while (n_done == start_n && k < budget) begin
            cyc();
            k++;
        end
        chk({tag, "_done_seen"}, 64'(n_done != start_n), 64'(1));
    endtask

    initial begin
        int k;
        wrst_n          = 1'b0;
        cfg_start       = 1'b0;
        cfg_base_addr   = '0;
        cfg_total_words = '0;
        wr_push         = 1'b0;
        fifo_data       = '0;
        axi.aw_ready    = 1'b1;
        axi.w_ready     = 1'b1;
        axi.b_valid     = 1'b0;
        axi.b_resp      = 2'b00;
        clr();

        repeat (3) cyc();
        chk("rst_outputs", 64'({busy, done, err, en_read_sync, axi.aw_valid, axi.w_valid,
                                axi.w_last, axi.b_ready}), 64'(0));
        chk("rst_aw_bus", 64'({axi.aw_addr, axi.aw_len}), 64'(0));
        wrst_n = 1'b1;
        cyc();

        // Single 4-word transfer.
        clr();
        exp_aw.push_back(aw_exp_t'{addr: 32'h1000, len: 8'd3});
        exp_last.push_back(1'b0); exp_last.push_back(1'b0);
        exp_last.push_back(1'b0); exp_last.push_back(1'b1);
        start(32'h1000, 4);
        chk("t1_busy", 64'(busy), 64'(1));
        push_left = 4;
        wait_done(60, "t1");
        repeat (3) cyc();
        chk("t1_n_aw", 64'(n_aw), 64'(1));
        chk("t1_n_pop", 64'(n_pop), 64'(4));
        chk("t1_n_done", 64'(n_done), 64'(1));
        chk("t1_level", 64'(dut.level), 64'(0));
        chk("t1_aw_left", 64'(exp_aw.size()), 64'(0));
        chk("t1_busy_end", 64'(busy), 64'(0));

        // 10 words: two full bursts and a 2-beat tail.
        clr();
        exp_aw.push_back(aw_exp_t'{addr: 32'h1000, len: 8'd3});
        exp_aw.push_back(aw_exp_t'{addr: 32'h1010, len: 8'd3});
        exp_aw.push_back(aw_exp_t'{addr: 32'h1020, len: 8'd1});
        for (int i = 0; i < 10; i++) exp_last.push_back(i == 3 || i == 7 || i == 9);
        start(32'h1000, 10);
        push_left = 10;
        wait_done(200, "t2");
        repeat (2) cyc();
        chk("t2_n_aw", 64'(n_aw), 64'(3));
        chk("t2_n_pop", 64'(n_pop), 64'(10));
        chk("t2_last_left", 64'(exp_last.size()), 64'(0));
        chk("t2_level", 64'(dut.level), 64'(0));

        // Late data, AW backpressure, then W backpressure.
        clr();
        plan(32'h2000, 4);
        start(32'h2000, 4);
        aw_rdy_en = 1'b0;
        push_left = 2;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t3_aw_wait", 64'(axi.aw_valid), 64'(0));
        end
        push_left = 2;
        k = 0;
        while (!axi.aw_valid && k < 10) begin
            cyc();
            k++;
        end
        chk("t3_aw_up", 64'(axi.aw_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_aw_hold", 64'({axi.aw_valid, axi.aw_addr, axi.aw_len}),
                64'({1'b1, 32'h2000, 8'd3}));
        end
        aw_rdy_en = 1'b1;
        w_mode    = 1;
        wait_done(80, "t3");
        w_mode = 0;
        repeat (2) cyc();
        chk("t3_n_pop", 64'(n_pop), 64'(4));
        chk("t3_stalled", 64'(n_stall > 0), 64'(1));

        // Slave error on the first of two bursts.
        clr();
        resp_q.push_back(2'b10);
        plan(32'h3000, 8);
        start(32'h3000, 8);
        push_left = 8;
        wait_done(150, "t4");
        chk("t4_err", 64'(err), 64'(1));
        chk("t4_n_aw", 64'(n_aw), 64'(2));
        repeat (3) cyc();
        chk("t4_err_sticky", 64'(err), 64'(1));
        chk("t4_n_done", 64'(n_done), 64'(1));

        // Zero-length transfer also clears err.
        clr();
        start(32'h0, 0);
        chk("t5_done", 64'({done, busy, err}), 64'(3'b100));
        cyc();
        chk("t5_done_off", 64'(done), 64'(0));
        repeat (3) cyc();
        chk("t5_n_aw", 64'(n_aw), 64'(0));
        chk("t5_n_done", 64'(n_done), 64'(1));

        // cfg_start while busy is ignored.
        clr();
        plan(32'h4000, 4);
        start(32'h4000, 4);
        repeat (2) cyc();
        start(32'h5000, 8);
        chk("t6_busy", 64'(busy), 64'(1));
        push_left = 4;
        wait_done(60, "t6");
        repeat (3) cyc();
        chk("t6_n_aw", 64'(n_aw), 64'(1));
        chk("t6_n_pop", 64'(n_pop), 64'(4));
        chk("t6_aw_left", 64'(exp_aw.size()), 64'(0));

        // Pushes overlapping pops; two words stay buffered.
        clr();
        plan(32'h6000, 4);
        start(32'h6000, 4);
        push_left = 6;
        wait_done(60, "t7");
        repeat (2) cyc();
        chk("t7_overlap", 64'(n_both > 0), 64'(1));
        chk("t7_level", 64'(dut.level), 64'(2));

        // Reset asserted mid-DATA.
        clr();
        plan(32'h7000, 4);
        start(32'h7000, 4);
        w_mode    = 2;
        push_left = 2;
        k = 0;
        while (!axi.w_valid && k < 20) begin
            cyc();
            k++;
        end
        chk("t8_in_data", 64'(axi.w_valid), 64'(1));
        wrst_n = 1'b0;
        #1;
        chk("t8_rst_outputs", 64'({busy, done, err, en_read_sync, axi.aw_valid, axi.w_valid,
                                   axi.w_last, axi.b_ready}), 64'(0));
        chk("t8_rst_w_data", 64'(axi.w_data), 64'(0));
        fifo_q.delete();
        exp_aw.delete();
        exp_last.delete();
        fifo_data   = '0;
        b_pend      = 1'b0;
        axi.b_valid = 1'b0;
        stall_prev  = 1'b0;
        both_prev   = 1'b0;
        w_mode      = 0;
        repeat (2) cyc();
        wrst_n = 1'b1;
        cyc();
        chk("t8_state_idle", 64'(dut.state_q), 64'(IDLE));
        chk("t8_busy", 64'(busy), 64'(0));
        chk("t8_level", 64'(dut.level), 64'(0));

        // Normal operation after the abandoned burst.
        clr();
        plan(32'h8000, 4);
        start(32'h8000, 4);
        push_left = 4;
        wait_done(60, "t9");
        repeat (2) cyc();
        chk("t9_n_aw", 64'(n_aw), 64'(1));
        chk("t9_n_pop", 64'(n_pop), 64'(4));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
